// File: rtl/dac_stream_if.sv
// ============================================================================
// Module   : dac_stream_if
// Purpose  : Sample stream handshake carrying 8-bit DAC codes into the queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dac_stream_if;
   logic [7:0] s_in;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_in, output s_valid, input s_ready);
   modport slave  (input s_in, input s_valid, output s_ready);
endinterface

`default_nettype wire

// File: rtl/dac_stream.sv
// ============================================================================
// Module   : dac_stream
// Purpose  : Sample FIFO paced out to a parallel R-2R DAC with underrun tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_stream #(
   parameter int         DEPTH = 4,
   parameter logic [7:0] MID   = 8'h80
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       enable,
   input  wire logic [15:0]                rate,
   input  wire logic                       clear_underrun,
   dac_stream_if.slave                     s,
   output logic [7:0]                      dac_out,
   output logic                            sample_tick,
   output logic [$clog2(DEPTH):0]          level,
   output logic                            underrun,
   output logic [7:0]                      underrun_cnt
);

   localparam int                  c_ADDR_W = $clog2(DEPTH);
   localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(DEPTH);

   logic [7:0]          r_mem [DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_ADDR_W:0]   r_level;
   logic [15:0]         r_cnt;
   logic [7:0]          r_dac;
   logic                r_tick;
   logic                r_underrun;
   logic [7:0]          r_under_cnt;
   logic                r_live;

   logic [15:0] w_eff;
   logic        w_event;
   logic        w_push;
   logic        w_pop;
   logic        w_under;

   // r_live keeps s_ready low while reset is held and for the release cycle.
   assign s.s_ready = r_live && (r_level != c_FULL);

   assign w_eff   = (rate == 16'd0) ? 16'd1 : rate;
   assign w_event = enable && (r_cnt >= (w_eff - 16'd1));
   assign w_push  = s.s_valid && s.s_ready;
   assign w_pop   = w_event && (r_level != '0);
   assign w_under = w_event && (r_level == '0);

   assign dac_out      = r_dac;
   assign sample_tick  = r_tick;
   assign level        = r_level;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_under_cnt;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s.s_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_cnt       <= '0;
         r_dac       <= MID;
         r_tick      <= 1'b0;
         r_underrun  <= 1'b0;
         r_under_cnt <= '0;
         r_live      <= 1'b0;
      end else begin
         r_live <= 1'b1;
         r_tick <= w_event;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_dac    <= r_mem[r_rd_ptr];
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase

         if (w_event) begin
            r_cnt <= '0;
         end else if (enable) begin
            r_cnt <= r_cnt + 16'd1;
         end else begin
            r_cnt <= '0;
         end

         // A clear that coincides with an underrun still records that event.
         if (clear_underrun) begin
            r_underrun  <= w_under;
            r_under_cnt <= w_under ? 8'd1 : 8'd0;
         end else if (w_under) begin
            r_underrun <= 1'b1;
            if (r_under_cnt != 8'hFF) begin
               r_under_cnt <= r_under_cnt + 8'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire
